lcd_hd44780_responder: RTL and testbench

//  Cycle-based HD44780-compatible display model: the responder end of the 8-bit LCD bus (RS/RW/EN/DATA).

---
 rtl/lcd_hd44780_responder.sv | 186 ++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: HD44780-style 8-bit bus responder with DDRAM, AC, busy timing and error flags; optional init-sequence checker under INIT_CHECK_EN
module lcd_hd44780_responder #(
    parameter int BUSY_SHORT = 1850,
    parameter int BUSY_LONG  = 76000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       id_inc,
    output logic       entry_shift,
    input  logic [6:0] view_addr,
    output logic [7:0] view_char,
    output logic       busy_viol,
    output logic       cmd_err
);
    localparam int CW = $clog2(BUSY_LONG + 1);
    localparam logic [CW-1:0] SHORT_C = CW'(BUSY_SHORT);
    localparam logic [CW-1:0] LONG_C  = CW'(BUSY_LONG);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [1:0]    en_q, rs_q, rw_q;
    logic [7:0]    d_q1, d;
    logic          en_d;
    logic          en_s, rs_s, rw_s, rise, fall, wr, rd, ready, fs_init;
    logic [7:0]    mem [80];
    logic [CW-1:0] cnt;
    logic          sweep;
    logic [6:0]    sweep_idx, ac_idx, view_idx;
    logic          ac_ok, view_ok;

    function automatic logic [6:0] idx_of(input logic [6:0] a, input logic tl);
        return (tl && a[6]) ? a - 7'd24 : a;
    endfunction

    function automatic logic addr_ok(input logic [6:0] a, input logic tl);
        return tl ? (a <= 7'h27 || (a >= 7'h40 && a <= 7'h67)) : (a <= 7'h4f);
    endfunction

    function automatic logic [6:0] step(input logic [6:0] a, input logic tl, input logic inc);
        if (tl)
            return inc ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
                       : (a == 7'h00 ? 7'h67 : a == 7'h40 ? 7'h27 : a - 7'd1);
        return inc ? (a == 7'h4f ? 7'h00 : a + 7'd1) : (a == 7'h00 ? 7'h4f : a - 7'd1);
    endfunction

    assign en_s        = en_q[1];
    assign rs_s        = rs_q[1];
    assign rw_s        = rw_q[1];
    assign rise        = en_s & ~en_d;
    assign fall        = ~en_s & en_d;
    assign wr          = fall & ~rw_s;
    assign rd          = fall & rw_s;
    assign busy        = cnt != '0;
    assign lcd_data_oe = en_s & rw_s;
    assign fs_init     = !rs_s && d[7:4] == 4'b0011;
    assign ac_idx      = idx_of(ac, two_line);
    assign ac_ok       = ac_idx < 7'd80;
    assign view_idx    = idx_of(view_addr, two_line);
    assign view_ok     = view_idx < 7'd80;

`ifdef INIT_CHECK_EN
    typedef enum logic [1:0] {WAIT_FS1, WAIT_FS2, WAIT_FS3, READY} init_t;
    init_t st, st_n;

    // init state register
    always_ff @(posedge clk) begin
        st <= rst ? WAIT_FS1 : st_n;
    end

    // advance one step per accepted 0b0011xxxx instruction write
    always_comb begin
        st_n = st;
        if (wr && !busy && fs_init)
            st_n = st == WAIT_FS1 ? WAIT_FS2 : st == WAIT_FS2 ? WAIT_FS3 : READY;
    end

    assign ready = st == READY;
`else
    assign ready = 1'b1;
`endif

    // two-flop synchronizers for the asynchronous bus, plus EN history for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= '0;
            rs_q <= '0;
            rw_q <= '0;
            d_q1 <= '0;
            d    <= '0;
            en_d <= 1'b0;
        end else begin
            en_q <= {en_q[0], lcd_en};
            rs_q <= {rs_q[0], lcd_rs};
            rw_q <= {rw_q[0], lcd_rw};
            d_q1 <= lcd_data_in;
            d    <= d_q1;
            en_d <= en_s;
        end
    end

    // command/data execution, busy timer, clear sweep and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            ac          <= '0;
            id_inc      <= 1'b1;
            entry_shift <= 1'b0;
            disp_on     <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            two_line    <= 1'b0;
            cnt         <= '0;
            busy_viol   <= 1'b0;
            cmd_err     <= 1'b0;
            sweep       <= 1'b0;
            sweep_idx   <= '0;
            for (int i = 0; i < 80; i++) mem[i] <= 8'h20;
        end else begin
            if (busy) cnt <= cnt - ONE_C;
            if (sweep) begin
                mem[sweep_idx] <= 8'h20;
                sweep_idx      <= sweep_idx + 7'd1;
                if (sweep_idx == 7'd79) sweep <= 1'b0;
            end
            if (rd && rs_s) ac <= step(ac, two_line, id_inc);
            if (wr && busy) begin
                busy_viol <= 1'b1;
            end else if (wr && !ready && !fs_init) begin
                cmd_err <= 1'b1;
            end else if (wr) begin
                cnt <= SHORT_C;
                if (rs_s) begin
                    if (ac_ok) mem[ac_idx] <= d;
                    ac <= step(ac, two_line, id_inc);
                end else if (d[7]) begin
                    if (addr_ok(d[6:0], two_line)) ac <= d[6:0];
                    else cmd_err <= 1'b1;
                end else if (d[6]) begin
                    cmd_err <= 1'b1;
                end else if (d[5]) begin
                    if (d[4]) two_line <= d[3];
                    else cmd_err <= 1'b1;
                end else if (d[4]) begin
                    if (!d[3]) ac <= step(ac, two_line, d[2]);
                end else if (d[3]) begin
                    {disp_on, cursor_on, blink_on} <= d[2:0];
                end else if (d[2]) begin
                    {id_inc, entry_shift} <= d[1:0];
                end else if (d[1]) begin
                    ac  <= '0;
                    cnt <= LONG_C;
                end else if (d[0]) begin
                    ac        <= '0;
                    id_inc    <= 1'b1;
                    cnt       <= LONG_C;
                    sweep     <= 1'b1;
                    sweep_idx <= '0;
                end else begin
                    cmd_err <= 1'b1;
                end
            end
        end
    end

    // read data captured when EN rises and held through the rest of the cycle
    always_ff @(posedge clk) begin
        if (rst) lcd_data_out <= '0;
        else if (rise) lcd_data_out <= rs_s ? (ac_ok ? mem[ac_idx] : 8'h20) : {busy, ac};
    end

    // registered inspection port
    always_ff @(posedge clk) begin
        if (rst) view_char <= 8'h20;
        else view_char <= view_ok ? mem[view_idx] : 8'h20;
    end
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: scoreboard bench for the HD44780 responder (BUSY_SHORT=20, BUSY_LONG=100)
module tb_lcd_hd44780_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_data_in = '0;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe, busy, disp_on, cursor_on, blink_on, two_line, id_inc, entry_shift;
    logic [6:0] ac;
    logic [6:0] view_addr = '0;
    logic [7:0] view_char;
    logic       busy_viol, cmd_err;
    int         n_checks = 0, n_err = 0, busy_cycles = 0;
    logic [7:0] exp_q[$];

    lcd_hd44780_responder #(.BUSY_SHORT(20), .BUSY_LONG(100)) dut (
        .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .busy(busy), .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .two_line(two_line), .id_inc(id_inc), .entry_shift(entry_shift),
        .view_addr(view_addr), .view_char(view_char), .busy_viol(busy_viol), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy) busy_cycles++;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] dat, input string tag);
        @(negedge clk);
        lcd_rs = rs;
        lcd_rw = rw;
        lcd_data_in = dat;
        repeat (2) @(negedge clk);
        lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        if (rw) begin
            check({tag, "_oe"}, lcd_data_oe, 1);
            if (exp_q.size() != 0) check(tag, lcd_data_out, exp_q.pop_front());
        end
        lcd_en = 1'b0;
        repeat (3) @(negedge clk);
        if (rw) check({tag, "_oe_off"}, lcd_data_oe, 0);
        lcd_rw = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic lcd_write(input logic rs, input logic [7:0] dat);
        xfer(rs, 1'b0, dat, "wr");
        wait_idle();
    endtask

    task automatic lcd_read(input logic rs, input logic [7:0] exp, input string tag);
        exp_q.push_back(exp);
        xfer(rs, 1'b1, 8'h00, tag);
    endtask

    task automatic view(input logic [6:0] a, input logic [7:0] exp, input string tag);
        view_addr = a;
        repeat (2) @(negedge clk);
        check(tag, view_char, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ac", ac, 0);
        check("rst_oe", lcd_data_oe, 0);
        check("rst_dout", lcd_data_out, 0);
        check("rst_disp", {disp_on, cursor_on, blink_on, two_line}, 0);
        check("rst_id", {id_inc, entry_shift}, 2'b10);
        check("rst_flags", {busy_viol, cmd_err}, 0);
        view(7'h10, 8'h20, "rst_view");
`ifdef INIT_CHECK_EN
        lcd_write(1'b0, 8'h0C);
        check("init_cmd_err", cmd_err, 1);
        check("init_disp_off", disp_on, 0);
        lcd_write(1'b0, 8'h30);
        lcd_write(1'b0, 8'h30);
`endif
        lcd_write(1'b0, 8'h38);
        lcd_write(1'b0, 8'h0C);
        lcd_write(1'b0, 8'h06);
        check("cfg_two_line", two_line, 1);
        check("cfg_disp", {disp_on, cursor_on, blink_on}, 3'b100);
        check("cfg_id", id_inc, 1);
        check("cfg_viol", busy_viol, 0);
`ifndef INIT_CHECK_EN
        check("cfg_cmd_err", cmd_err, 0);
`endif
        lcd_write(1'b0, 8'hA7);
        check("set_ac27", ac, 7'h27);
        lcd_write(1'b1, 8'h41);
        check("wrap_27_40", ac, 7'h40);
        view(7'h27, 8'h41, "view_27");
        lcd_write(1'b0, 8'h04);
        lcd_write(1'b0, 8'h80);
        lcd_write(1'b1, 8'h42);
        check("wrap_00_67", ac, 7'h67);
        view(7'h00, 8'h42, "view_00");
        lcd_write(1'b0, 8'hC0);
        lcd_write(1'b1, 8'h43);
        check("wrap_40_27", ac, 7'h27);
        lcd_write(1'b0, 8'h06);
        lcd_write(1'b0, 8'h85);
        busy_cycles = 0;
        xfer(1'b1, 1'b0, 8'h55, "wr");
        xfer(1'b1, 1'b0, 8'h66, "wr");
        wait_idle();
        check("viol_busy_len", busy_cycles, 20);
        check("viol_flag", busy_viol, 1);
        check("viol_ac", ac, 7'h06);
        view(7'h05, 8'h55, "viol_view5");
        view(7'h06, 8'h20, "viol_view6");
        lcd_write(1'b0, 8'h14);
        check("shift_right", ac, 7'h07);
        lcd_write(1'b0, 8'h10);
        check("shift_left", ac, 7'h06);
        lcd_write(1'b0, 8'h18);
        check("disp_shift", ac, 7'h06);
        lcd_write(1'b0, 8'h80);
        lcd_write(1'b0, 8'h10);
        check("shift_wrap", ac, 7'h67);
        lcd_write(1'b0, 8'h85);
        lcd_read(1'b1, 8'h55, "rd_data5");
        check("rd_data_ac", ac, 7'h06);
        lcd_read(1'b0, 8'h06, "rd_status_idle");
        lcd_write(1'b0, 8'hE8);
        check("bad_addr_err", cmd_err, 1);
        check("bad_addr_ac", ac, 7'h06);
        lcd_write(1'b0, 8'h80);
        for (int i = 0; i < 80; i++) lcd_write(1'b1, 8'(8'h30 + i));
        view(7'h10, 8'h40, "fill_10");
        view(7'h40, 8'h58, "fill_40");
        lcd_write(1'b0, 8'h04);
        busy_cycles = 0;
        xfer(1'b0, 1'b0, 8'h01, "wr");
        lcd_read(1'b0, 8'h80, "rd_status_busy");
        wait_idle();
        check("clr_busy_len", busy_cycles, 100);
        check("clr_ac", ac, 0);
        check("clr_id", id_inc, 1);
        for (int i = 0; i < 40; i++) begin
            view(7'(i), 8'h20, "clr_view_l1");
            view(7'(8'h40 + i), 8'h20, "clr_view_l2");
        end
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
